// File: rtl/pc_gen_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_unit_pkg
// Shared definitions for the fetch-stage PC generator.
//   pc_mux_e   : encoding of the 'branch' target-select input
//   pc_state_e : PC generator FSM state encoding
//   BOOT_CNT_W : width of the boot delay counter (BOOT_DELAY is 1..15)
// -----------------------------------------------------------------------------
package pc_gen_unit_pkg;

  typedef enum logic [1:0] {
    PC_MUX_PC_PLUS  = 2'b00,
    PC_MUX_ALU_OUT  = 2'b01,
    PC_MUX_PC_ADDER = 2'b10,
    PC_MUX_TRAP     = 2'b11
  } pc_mux_e;

  typedef enum logic [1:0] {
    PC_ST_BOOT = 2'b00,
    PC_ST_RUN  = 2'b01,
    PC_ST_HOLD = 2'b10
  } pc_state_e;

  localparam int BOOT_CNT_W = 4;

endpackage

// File: rtl/pc_gen_unit_target_sel.sv
// -----------------------------------------------------------------------------
// pc_target_sel
// Combinational redirect target selection for pc_gen_unit.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned targets -> trap).
// Ports:
//   branch          in  2     target select (pc_mux_e encoding)
//   alu_result      in  XLEN  ALU redirect target
//   pc_adder_result in  XLEN  PC adder redirect target
//   redirect        out 1     branch selects something other than PC+STEP
//   misaligned      out 1     (macro only) selected target not STEP-aligned
//   raw_target      out XLEN  (macro only) target before trap substitution
//   target          out XLEN  final redirect target
// -----------------------------------------------------------------------------
module pc_target_sel
  import pc_gen_unit_pkg::*;
#(
  parameter int                XLEN        = 32,
`ifdef PC_MISALIGN_TRAP_EN
  parameter int                STEP        = 4,
`endif
  parameter logic [XLEN-1:0]   TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
  input  logic [1:0]      branch,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_adder_result,
  output logic            redirect,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misaligned,
  output logic [XLEN-1:0] raw_target,
`endif
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] sel_target;

  always_comb begin
    sel_target = '0;
    case (pc_mux_e'(branch))
      PC_MUX_ALU_OUT:  sel_target = alu_result;
      PC_MUX_PC_ADDER: sel_target = pc_adder_result;
      PC_MUX_TRAP:     sel_target = TRAP_VECTOR;
      default:         sel_target = '0;
    endcase
  end

  assign redirect = (pc_mux_e'(branch) != PC_MUX_PC_PLUS);

`ifdef PC_MISALIGN_TRAP_EN
  // STEP is a power of two (2 or 4), so the low bits give target % STEP.
  assign misaligned = redirect && ((sel_target & XLEN'(STEP - 1)) != '0);
  assign raw_target = sel_target;
  assign target     = misaligned ? TRAP_VECTOR : sel_target;
`else
  assign target     = sel_target;
`endif

endmodule

// File: rtl/pc_gen_unit.sv
// -----------------------------------------------------------------------------
// pc_gen_unit
// Fetch-stage program counter with valid/ready handshake to instruction memory,
// a post-reset boot delay and buffering of redirects that arrive while stalled.
// Optional feature macro: PC_MISALIGN_TRAP_EN (adds misalign / bad_addr).
// Ports:
//   clk             in  1     system clock, rising edge
//   rst_n           in  1     synchronous active-low reset
//   en              in  1     advance enable (0 freezes pc, drops redirects)
//   branch          in  2     target select (pc_mux_e)
//   alu_result      in  XLEN  redirect target from the ALU
//   pc_adder_result in  XLEN  redirect target from the PC adder
//   fetch_ready     in  1     instruction memory accepts the request
//   fetch_valid     out 1     fetch request valid, address is pc
//   pc              out XLEN  current fetch address (registered)
//   pc_next         out XLEN  value pc takes at the next edge
//   fetch_kill      out 1     previously accepted word is wrong-path
//   misalign        out 1     (macro only) pulse with fetch_kill on bad target
//   bad_addr        out XLEN  (macro only) last offending redirect target
// -----------------------------------------------------------------------------
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              BOOT_DELAY   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      branch,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_adder_result,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr,
`endif
  output logic            fetch_kill
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_INIT = BOOT_CNT_W'(BOOT_DELAY - 1);

  pc_state_e             state_q, state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       pending_q, pending_d;
  logic                  kill_q, kill_d;

  logic                  redirect;
  logic [XLEN-1:0]       target;
  logic                  accept;

`ifdef PC_MISALIGN_TRAP_EN
  logic                  sel_bad;
  logic [XLEN-1:0]       sel_raw;
  logic                  pend_bad_q, pend_bad_d;
  logic [XLEN-1:0]       pend_raw_q, pend_raw_d;
  logic                  misalign_q, misalign_d;
  logic [XLEN-1:0]       bad_addr_q, bad_addr_d;
`endif

  pc_target_sel #(
    .XLEN        (XLEN),
`ifdef PC_MISALIGN_TRAP_EN
    .STEP        (STEP),
`endif
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_target_sel (
    .branch          (branch),
    .alu_result      (alu_result),
    .pc_adder_result (pc_adder_result),
    .redirect        (redirect),
`ifdef PC_MISALIGN_TRAP_EN
    .misaligned      (sel_bad),
    .raw_target      (sel_raw),
`endif
    .target          (target)
  );

  assign fetch_valid = (state_q != PC_ST_BOOT);
  assign accept      = fetch_valid && fetch_ready;

  // Next-state logic. With en=0 nothing moves: a completed handshake simply
  // re-fetches the same pc, and a HOLD pending target survives untouched.
  // In HOLD a redirect on the accepting edge wins over the buffered target.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    kill_d     = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    pend_bad_d = pend_bad_q;
    pend_raw_d = pend_raw_q;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;
`endif
    case (state_q)
      PC_ST_BOOT: begin
        if (boot_cnt_q == '0) begin
          state_d = PC_ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 1'b1;
        end
      end
      PC_ST_RUN: begin
        if (en) begin
          if (redirect) begin
            if (accept) begin
              pc_d   = target;
              kill_d = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
              if (sel_bad) begin
                misalign_d = 1'b1;
                bad_addr_d = sel_raw;
              end
`endif
            end else begin
              pending_d = target;
              state_d   = PC_ST_HOLD;
`ifdef PC_MISALIGN_TRAP_EN
              pend_bad_d = sel_bad;
              pend_raw_d = sel_raw;
`endif
            end
          end else if (accept) begin
            pc_d = pc_q + XLEN'(STEP);
          end
        end
      end
      PC_ST_HOLD: begin
        if (en) begin
          if (redirect) begin
            pending_d = target;
`ifdef PC_MISALIGN_TRAP_EN
            pend_bad_d = sel_bad;
            pend_raw_d = sel_raw;
`endif
          end
          if (accept) begin
            pc_d    = pending_d;
            state_d = PC_ST_RUN;
            kill_d  = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if (pend_bad_d) begin
              misalign_d = 1'b1;
              bad_addr_d = pend_raw_d;
            end
`endif
          end
        end
      end
      default: state_d = PC_ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= PC_ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
      pc_q       <= RESET_VECTOR;
      pending_q  <= '0;
      kill_q     <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      pend_bad_q <= 1'b0;
      pend_raw_q <= '0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      kill_q     <= kill_d;
`ifdef PC_MISALIGN_TRAP_EN
      pend_bad_q <= pend_bad_d;
      pend_raw_q <= pend_raw_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign pc_next    = pc_d;
  assign fetch_kill = kill_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign   = misalign_q;
  assign bad_addr   = bad_addr_q;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_unit
// Self-checking bench for pc_gen_unit (BOOT_DELAY=3, XLEN=32, STEP=4).
// Honours PC_MISALIGN_TRAP_EN for the optional misalignment outputs.
// -----------------------------------------------------------------------------
module tb_pc_gen_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  branch;
  logic [31:0] alu_result;
  logic [31:0] pc_adder_result;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        fetch_kill;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] bad_addr;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [1:0]  branch;
    logic [31:0] alu;
    logic [31:0] adder;
    logic        ready;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_kill;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        kill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  pc_gen_unit #(
    .XLEN         (32),
    .STEP         (4),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .BOOT_DELAY   (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .branch          (branch),
    .alu_result      (alu_result),
    .pc_adder_result (pc_adder_result),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .pc              (pc),
    .pc_next         (pc_next),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign        (misalign),
    .bad_addr        (bad_addr),
`endif
    .fetch_kill      (fetch_kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic e, input logic [1:0] b,
                         input logic [31:0] a, input logic [31:0] d, input logic rdy,
                         input logic [31:0] epc, input logic ev, input logic ek);
    vec_t v;
    v.rst_n = r; v.en = e; v.branch = b; v.alu = a; v.adder = d; v.ready = rdy;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_kill = ek;
    vecs.push_back(v);
  endtask

  // Pops the oldest expectation and compares it with the post-edge outputs.
  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("pc", pc, e.pc);
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.valid});
      check("fetch_kill", {31'd0, fetch_kill}, {31'd0, e.kill});
    end
  endtask

  // Drives one cycle of inputs, checks pc_next before the edge, then the
  // registered outputs just after it.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    rst_n           = v.rst_n;
    en              = v.en;
    branch          = v.branch;
    alu_result      = v.alu;
    pc_adder_result = v.adder;
    fetch_ready     = v.ready;
    e.pc = v.exp_pc; e.valid = v.exp_valid; e.kill = v.exp_kill;
    sb_q.push_back(e);
    #1;
    if (v.rst_n) check("pc_next", pc_next, v.exp_pc);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic run_vec(input logic r, input logic e, input logic [1:0] b,
                         input logic [31:0] a, input logic [31:0] d, input logic rdy,
                         input logic [31:0] epc, input logic ev, input logic ek);
    vec_t v;
    v.rst_n = r; v.en = e; v.branch = b; v.alu = a; v.adder = d; v.ready = rdy;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_kill = ek;
    apply_stimulus(v);
  endtask

  initial begin
    // rst en br alu adder rdy | pc valid kill
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_0000, 0, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_0000, 0, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_0000, 1, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_0004, 1, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_0008, 1, 0);
    add_vec(1, 1, 2'd1, 32'h1000, 32'h0,    1, 32'h0000_1000, 1, 1);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_1004, 1, 0);
    add_vec(1, 1, 2'd2, 32'h0,    32'h2000, 0, 32'h0000_1004, 1, 0);
    add_vec(1, 1, 2'd1, 32'h3000, 32'h0,    0, 32'h0000_1004, 1, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    0, 32'h0000_1004, 1, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_3000, 1, 1);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_3004, 1, 0);
    add_vec(1, 0, 2'd3, 32'h0,    32'h0,    1, 32'h0000_3004, 1, 0);
    add_vec(1, 0, 2'd3, 32'h0,    32'h0,    1, 32'h0000_3004, 1, 0);
    add_vec(1, 0, 2'd3, 32'h0,    32'h0,    1, 32'h0000_3004, 1, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_3008, 1, 0);
    add_vec(1, 0, 2'd0, 32'h0,    32'h0,    0, 32'h0000_3008, 1, 0);
    add_vec(1, 1, 2'd3, 32'h0,    32'h0,    1, 32'h0000_0100, 1, 1);
    add_vec(1, 1, 2'd2, 32'h0,    32'h2000, 1, 32'h0000_2000, 1, 1);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_2004, 1, 0);
    add_vec(1, 1, 2'd1, 32'h5000, 32'h0,    0, 32'h0000_2004, 1, 0);
    add_vec(1, 1, 2'd2, 32'h0,    32'h6000, 1, 32'h0000_6000, 1, 1);
    add_vec(1, 1, 2'd1, 32'h7000, 32'h0,    0, 32'h0000_6000, 1, 0);
    add_vec(1, 0, 2'd0, 32'h0,    32'h0,    1, 32'h0000_6000, 1, 0);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_7000, 1, 1);
    add_vec(1, 1, 2'd0, 32'h0,    32'h0,    1, 32'h0000_7004, 1, 0);

    rst_n = 1'b0; en = 1'b0; branch = 2'd0;
    alu_result = '0; pc_adder_result = '0; fetch_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_valid", {31'd0, fetch_valid}, 32'd0);
    check("reset_kill", {31'd0, fetch_kill}, 32'd0);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Wrap modulo 2^32, then reset while a redirect is pending in HOLD.
    run_vec(1, 1, 2'd1, 32'hFFFF_FFFC, 32'h0, 1, 32'hFFFF_FFFC, 1, 1);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, 1, 0);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0004, 1, 0);
    run_vec(1, 1, 2'd1, 32'h8000, 32'h0, 0, 32'h0000_0004, 1, 0);
    run_vec(0, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, 0, 0);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, 0, 0);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, 0, 0);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, 1, 0);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0004, 1, 0);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0008, 1, 0);

`ifdef PC_MISALIGN_TRAP_EN
    check("reset_bad_addr", bad_addr, 32'h0);
    run_vec(1, 1, 2'd1, 32'h1002, 32'h0, 1, 32'h0000_0100, 1, 1);
    check("misalign_pulse", {31'd0, misalign}, 32'd1);
    check("bad_addr", bad_addr, 32'h0000_1002);
    run_vec(1, 1, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0104, 1, 0);
    check("misalign_clear", {31'd0, misalign}, 32'd0);
    check("bad_addr_hold", bad_addr, 32'h0000_1002);
`endif

    if (sb_q.size() != 0) check("scoreboard_left", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
